crack: RTL and testbench
========================

CRACK -- requirements
Module: crack

Interface
REQ-001 SHALL have parameter KEY_START, default 24'h000000, first key tried.
REQ-002 SHALL have parameter KEY_STEP, default 24'h000001, key increment; 2 when two cores split the key space.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port en, input, 1, start request, sampled only while rdy=1.
REQ-006 SHALL have port rdy, output, 1, high only in IDLE.
REQ-007 SHALL have port stop, input, 1, abort request from a sibling core that found the key.
REQ-008 SHALL have port key, output, 24, last key tested; the found key when key_valid=1.
REQ-009 SHALL have port key_valid, output, 1, high when key holds a key that yields a printable plaintext.
REQ-010 SHALL have port arc4_en, output, 1, start pulse to the arc4 decrypter.
REQ-011 SHALL have port arc4_rdy, input, 1, ready from the arc4 decrypter.
REQ-012 SHALL have port arc4_key, output, 24, candidate key presented to arc4; equal to key.
REQ-013 SHALL have port pt_addr, output, 8, plaintext memory read address.
REQ-014 SHALL have port pt_rddata, input, 8, plaintext read data, valid one cycle after pt_addr.

Function
REQ-015 SHALL use these FSM states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, LEN_ADDR, LEN_CMP, BYTE_ADDR, BYTE_CMP, NEXT_KEY, DONE.
REQ-016 IDLE: rdy=1; on en=1, SHALL load key=KEY_START, clear key_valid, and go to LAUNCH.
REQ-017 LAUNCH: SHALL assert arc4_en=1 only while arc4_rdy=1 (single cycle), then go to WAIT_ACK; while arc4_rdy=0 it SHALL hold with arc4_en=0.
REQ-018 WAIT_ACK: SHALL wait for arc4_rdy=0 (busy acknowledged), then go to WAIT_DONE; this prevents a stale rdy being taken as completion.
REQ-019 WAIT_DONE: on arc4_rdy=1, SHALL go to LEN_ADDR.
REQ-020 LEN_ADDR: SHALL drive pt_addr=0. LEN_CMP: SHALL latch len=pt_rddata and set idx=1; len=0 SHALL go to NEXT_KEY (empty message rejected).
REQ-021 BYTE_ADDR: SHALL drive pt_addr=idx. BYTE_CMP: byte outside 8'h20..8'h7E SHALL go to NEXT_KEY; otherwise, if idx==len, SHALL set key_valid=1 and go to DONE, else idx+1 and go to BYTE_ADDR.
REQ-022 Check cost SHALL be 2 cycles per byte, including the length byte; idx SHALL be 8 bits and never wrap because len≤255.
REQ-023 NEXT_KEY: if key+KEY_STEP exceeds 24'hFFFFFF (carry out of 24-bit add), SHALL go to DONE with key_valid=0; else key+=KEY_STEP and go to LAUNCH.
REQ-024 stop=1 in any state other than IDLE/DONE SHALL go to DONE after the current arc4 job completes (WAIT_DONE sees arc4_rdy=1), with key_valid=0; arc4 is never left mid-job.
REQ-025 DONE: rdy=0; key/key_valid SHALL hold; SHALL return to IDLE on the cycle after en=0 is sampled (en used as level acknowledge).
REQ-026 en while not IDLE SHALL be ignored except as in REQ-025.
REQ-027 pt_addr SHALL be 0 in all states other than LEN_ADDR/BYTE_ADDR.
REQ-028 arc4_key SHALL equal key at all times.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force IDLE, key=KEY_START, key_valid=0, arc4_en=0, pt_addr=0, len=0, idx=0; rdy=1.
REQ-030 Reset asserted mid-job SHALL abandon the key search with no further arc4_en pulse; the first cycles after release SHALL be in IDLE.

Verification
REQ-031 Arc4 model returns pt=[3,'a','b','c'] for key 24'h000002 and garbage for other keys; en pulse, KEY_START=0, KEY_STEP=1 -> exactly 3 arc4_en pulses, key=24'h000002, key_valid=1, DONE.
REQ-032 pt=[2,'H',8'h7F] for every key -> byte rejected at idx 2; KEY_START=24'hFFFFFE -> tries FFFFFE, FFFFFF, then DONE with key_valid=0 and no wrap to 0.
REQ-033 pt[0]=0 for key 0, valid message for key 1 -> key 0 rejected, key_valid=1 with key=1.
REQ-034 arc4_rdy held 0 for 5 cycles after launch request -> arc4_en stays 0 until arc4_rdy=1, then exactly one 1-cycle pulse.
REQ-035 stop=1 during WAIT_DONE -> no new arc4_en; DONE with key_valid=0 after arc4_rdy rises.
REQ-036 rst_n=0 during BYTE_CMP -> rdy=1, key_valid=0, arc4_en=0 in the same cycle; a new en restarts from KEY_START.

Source files
------------

// File: rtl/crack_if.sv
// Link between the key-search core and its arc4 decrypter: start/ready
// handshake, candidate key, and the synchronous plaintext read port.
interface crack_if;
    logic        arc4_en;
    logic        arc4_rdy;
    logic [23:0] arc4_key;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_rddata;

    modport master (
        output arc4_en,
        output arc4_key,
        output pt_addr,
        input  arc4_rdy,
        input  pt_rddata
    );

    modport slave (
        input  arc4_en,
        input  arc4_key,
        input  pt_addr,
        output arc4_rdy,
        output pt_rddata
    );
endinterface

// File: rtl/crack.sv
// Brute-force key search: launch arc4 for each candidate key, then accept the
// key if the decrypted length-prefixed message is entirely printable ASCII.
module crack #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_STEP  = 24'h000001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic        stop,
    output logic [23:0] key,
    output logic        key_valid,
    crack_if.master     bus
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LAUNCH    = 4'd1,
        WAIT_ACK  = 4'd2,
        WAIT_DONE = 4'd3,
        LEN_ADDR  = 4'd4,
        LEN_CMP   = 4'd5,
        BYTE_ADDR = 4'd6,
        BYTE_CMP  = 4'd7,
        NEXT_KEY  = 4'd8,
        DONE      = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] key_q, key_d;
    logic        key_valid_q, key_valid_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic        stop_req_q, stop_req_d;
    logic [7:0]  pt_addr_q, pt_addr_d;
    logic        rdy_q, rdy_d;
    logic        arc4_en_s;
    logic [24:0] next_sum_s;
    logic        byte_ok_s;

    assign next_sum_s = {1'b0, key_q} + {1'b0, KEY_STEP};
    assign byte_ok_s  = (bus.pt_rddata >= 8'h20) && (bus.pt_rddata <= 8'h7E);

    // Next-state and datapath updates for the search sequencer.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        len_d       = len_q;
        idx_d       = idx_q;
        stop_req_d  = stop_req_q | stop;
        arc4_en_s   = 1'b0;
        pt_addr_d   = 8'h00;
        rdy_d       = 1'b0;

        case (state_q)
            IDLE: begin
                stop_req_d = 1'b0;
                if (en) begin
                    key_d       = KEY_START;
                    key_valid_d = 1'b0;
                    state_d     = LAUNCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                // No job is in flight yet, so an abort can finish right here.
                if (stop_req_d) begin
                    state_d = DONE;
                end else if (bus.arc4_rdy) begin
                    arc4_en_s = 1'b1;
                    state_d   = WAIT_ACK;
                end else begin
                    state_d = LAUNCH;
                end
            end
            WAIT_ACK: begin
                if (!bus.arc4_rdy) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (bus.arc4_rdy) begin
                    state_d = stop_req_d ? DONE : LEN_ADDR;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            LEN_ADDR: begin
                state_d = stop_req_d ? DONE : LEN_CMP;
            end
            LEN_CMP: begin
                len_d = bus.pt_rddata;
                idx_d = 8'd1;
                if (stop_req_d) begin
                    state_d = DONE;
                end else if (bus.pt_rddata == 8'h00) begin
                    state_d = NEXT_KEY;
                end else begin
                    state_d = BYTE_ADDR;
                end
            end
            BYTE_ADDR: begin
                state_d = stop_req_d ? DONE : BYTE_CMP;
            end
            BYTE_CMP: begin
                if (stop_req_d) begin
                    state_d = DONE;
                end else if (!byte_ok_s) begin
                    state_d = NEXT_KEY;
                end else if (idx_q == len_q) begin
                    key_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = BYTE_ADDR;
                end
            end
            NEXT_KEY: begin
                // A carry out means the key space is exhausted; never wrap to 0.
                if (stop_req_d || next_sum_s[24]) begin
                    state_d = DONE;
                end else begin
                    key_d   = next_sum_s[23:0];
                    state_d = LAUNCH;
                end
            end
            DONE: begin
                stop_req_d = 1'b0;
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d    = IDLE;
                stop_req_d = 1'b0;
            end
        endcase

        if (state_d == BYTE_ADDR) begin
            pt_addr_d = idx_d;
        end else begin
            pt_addr_d = 8'h00;
        end

        if (state_d == IDLE) begin
            rdy_d = 1'b1;
        end else begin
            rdy_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_q       <= KEY_START;
            key_valid_q <= 1'b0;
            len_q       <= 8'h00;
            idx_q       <= 8'h00;
            stop_req_q  <= 1'b0;
            pt_addr_q   <= 8'h00;
            rdy_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            stop_req_q  <= stop_req_d;
            pt_addr_q   <= pt_addr_d;
            rdy_q       <= rdy_d;
        end
    end

    assign rdy          = rdy_q;
    assign key          = key_q;
    assign key_valid    = key_valid_q;
    assign bus.arc4_en  = arc4_en_s;
    assign bus.arc4_key = key_q;
    assign bus.pt_addr  = pt_addr_q;

endmodule

// File: tb/tb_crack.sv
// Directed bench for crack: two cores (default range and top-of-range), each
// with a behavioural arc4 model whose plaintext depends on the launched key.
module tb_crack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0, stop_a = 1'b0, hold_a = 1'b0;
    logic        rdy_a, rdy_b, kv_a, kv_b;
    logic [23:0] key_a, key_b;

    crack_if ifa ();
    crack_if ifb ();

    crack dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .rdy(rdy_a), .stop(stop_a),
        .key(key_a), .key_valid(kv_a), .bus(ifa)
    );

    crack #(.KEY_START(24'hFFFFFE), .KEY_STEP(24'h000001)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .rdy(rdy_b), .stop(1'b0),
        .key(key_b), .key_valid(kv_b), .bus(ifb)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Plaintext produced by the arc4 model of core A for a given mode and key.
    function automatic logic [7:0] pt_a(input int mode, input logic [23:0] k, input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        case (mode)
            0: if (k == 24'd2) r = (a == 8'd0) ? 8'd3 : (a == 8'd1) ? 8'h61 : (a == 8'd2) ? 8'h62 : 8'h63;
               else            r = (a == 8'd0) ? 8'd3 : (a == 8'd2) ? 8'h01 : 8'h61;
            2: if (k == 24'd0)      r = 8'h00;
               else if (k == 24'd1) r = (a == 8'd0) ? 8'd2 : 8'h4B;
               else                 r = (a == 8'd0) ? 8'd1 : 8'h00;
            3: r = (a == 8'd0) ? 8'd1 : 8'h7F;
            4: if (k == 24'd5) r = (a == 8'd0) ? 8'd2 : (a == 8'd1) ? 8'h20 : 8'h7E;
               else if (k[0])  r = (a == 8'd0) ? 8'd1 : 8'h1F;
               else            r = (a == 8'd0) ? 8'd1 : 8'h7F;
            5: r = (a == 8'd0) ? 8'd255 : 8'h41;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    int          mode_a = 0, lat_a = 3, cnt_a = 0, pulses_a = 0, multi_a = 0;
    logic        m_rdy_a = 1'b1, prev_a = 1'b0;
    logic [23:0] mk_a = 24'h0;

    assign ifa.arc4_rdy = m_rdy_a & ~hold_a;

    always @(posedge clk) begin
        ifa.pt_rddata <= pt_a(mode_a, mk_a, ifa.pt_addr);
        prev_a <= ifa.arc4_en;
        if (ifa.arc4_en) begin
            pulses_a <= pulses_a + 1;
            if (prev_a) multi_a <= multi_a + 1;
            mk_a    <= ifa.arc4_key;
            m_rdy_a <= 1'b0;
            cnt_a   <= lat_a;
        end else if (cnt_a > 1) begin
            cnt_a <= cnt_a - 1;
        end else if (cnt_a == 1) begin
            cnt_a   <= 0;
            m_rdy_a <= 1'b1;
        end
    end

    int         cnt_b = 0, pulses_b = 0;
    logic       m_rdy_b = 1'b1;
    logic [7:0] maxaddr_b = 8'h00;

    assign ifb.arc4_rdy = m_rdy_b;

    always @(posedge clk) begin
        ifb.pt_rddata <= (ifb.pt_addr == 8'd0) ? 8'd2 : (ifb.pt_addr == 8'd1) ? 8'h48 : 8'h7F;
        if (ifb.pt_addr > maxaddr_b) maxaddr_b <= ifb.pt_addr;
        if (ifb.arc4_en) begin
            pulses_b <= pulses_b + 1;
            m_rdy_b  <= 1'b0;
            cnt_b    <= 2;
        end else if (cnt_b > 1) begin
            cnt_b <= cnt_b - 1;
        end else if (cnt_b == 1) begin
            cnt_b   <= 0;
            m_rdy_b <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic pulse_en(input bit b);
        @(posedge clk); #1;
        if (b) en_b = 1'b1; else en_a = 1'b1;
        @(posedge clk); #1;
        if (b) en_b = 1'b0; else en_a = 1'b0;
    endtask

    task automatic wait_rdy(input bit b, input int budget, input string nm);
        int n;
        n = 0;
        while (((b ? rdy_b : rdy_a) !== 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(b ? rdy_b : rdy_a), 32'd1);
    endtask

    typedef struct {
        int          mode;
        int          lat;
        logic [23:0] exp_key;
        logic        exp_kv;
        int          exp_pulses;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int p0, n;

        tbl[0] = '{mode: 0, lat: 3, exp_key: 24'd2, exp_kv: 1'b1, exp_pulses: 3};
        tbl[1] = '{mode: 2, lat: 1, exp_key: 24'd1, exp_kv: 1'b1, exp_pulses: 2};
        tbl[2] = '{mode: 5, lat: 4, exp_key: 24'd0, exp_kv: 1'b1, exp_pulses: 1};
        tbl[3] = '{mode: 4, lat: 2, exp_key: 24'd5, exp_kv: 1'b1, exp_pulses: 6};

        repeat (2) @(negedge clk);
        chk("reset_rdy", 32'(rdy_a), 32'd1);
        chk("reset_key", 32'(key_a), 32'd0);
        chk("reset_kv", 32'(kv_a), 32'd0);
        chk("reset_arc4_en", 32'(ifa.arc4_en), 32'd0);
        chk("reset_pt_addr", 32'(ifa.pt_addr), 32'd0);
        chk("reset_key_b", 32'(key_b), 32'hFFFFFE);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            mode_a = tbl[i].mode;
            lat_a  = tbl[i].lat;
            p0 = pulses_a;
            pulse_en(1'b0);
            chk($sformatf("v%0d_busy", i), 32'(rdy_a), 32'd0);
            wait_rdy(1'b0, 3000, $sformatf("v%0d_timeout", i));
            chk($sformatf("v%0d_key", i), 32'(key_a), 32'(tbl[i].exp_key));
            chk($sformatf("v%0d_kv", i), 32'(kv_a), 32'(tbl[i].exp_kv));
            chk($sformatf("v%0d_pulses", i), 32'(pulses_a - p0), 32'(tbl[i].exp_pulses));
            chk($sformatf("v%0d_arc4_key", i), 32'(ifa.arc4_key), 32'(tbl[i].exp_key));
        end
        chk("single_cycle_pulses", 32'(multi_a), 32'd0);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_kv", 32'(kv_a), 32'd0);
        chk("async_rst_key", 32'(key_a), 32'd0);
        #2 rst_n = 1'b1;

        // Top-of-range core: both keys rejected at idx 2, no wrap past FFFFFF.
        pulse_en(1'b1);
        wait_rdy(1'b1, 500, "b_timeout");
        chk("b_key", 32'(key_b), 32'hFFFFFF);
        chk("b_kv", 32'(kv_b), 32'd0);
        chk("b_pulses", 32'(pulses_b), 32'd2);
        chk("b_max_addr", 32'(maxaddr_b), 32'd2);

        // DONE holds while en stays high; release returns to IDLE.
        mode_a = 2; lat_a = 3;
        @(posedge clk); #1 en_a = 1'b1;
        repeat (60) @(negedge clk);
        chk("done_hold_rdy", 32'(rdy_a), 32'd0);
        chk("done_hold_kv", 32'(kv_a), 32'd1);
        chk("done_hold_key", 32'(key_a), 32'd1);
        @(posedge clk); #1 en_a = 1'b0;
        @(negedge clk);
        chk("done_hold_rdy_low_still", 32'(rdy_a), 32'd0);
        @(negedge clk);
        chk("done_release_rdy", 32'(rdy_a), 32'd1);

        // arc4 not ready at launch: no pulse until ready, then exactly one.
        mode_a = 5; lat_a = 2; hold_a = 1'b1;
        p0 = pulses_a;
        pulse_en(1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_arc4_en", 32'(ifa.arc4_en), 32'd0);
        end
        chk("hold_pulses", 32'(pulses_a - p0), 32'd0);
        hold_a = 1'b0;
        wait_rdy(1'b0, 1500, "hold_timeout");
        chk("hold_pulses_after", 32'(pulses_a - p0), 32'd1);
        chk("hold_single_cycle", 32'(multi_a), 32'd0);
        chk("hold_kv", 32'(kv_a), 32'd1);

        // Stop while arc4 is busy on the second key.
        mode_a = 3; lat_a = 8;
        p0 = pulses_a;
        pulse_en(1'b0);
        n = 0;
        while ((pulses_a - p0) < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stop_reach_second", 32'(pulses_a - p0), 32'd2);
        repeat (2) @(negedge clk);
        stop_a = 1'b1;
        @(negedge clk);
        stop_a = 1'b0;
        chk("stop_waits_arc4", 32'(rdy_a), 32'd0);
        wait_rdy(1'b0, 200, "stop_timeout");
        chk("stop_pulses", 32'(pulses_a - p0), 32'd2);
        chk("stop_kv", 32'(kv_a), 32'd0);
        chk("stop_key", 32'(key_a), 32'd1);

        // Reset in BYTE_CMP, then a fresh search from KEY_START.
        mode_a = 0; lat_a = 2;
        pulse_en(1'b0);
        n = 0;
        while (ifa.pt_addr == 8'd0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_byte", 32'(ifa.pt_addr != 8'd0), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_rdy", 32'(rdy_a), 32'd1);
        chk("rst_mid_kv", 32'(kv_a), 32'd0);
        chk("rst_mid_arc4_en", 32'(ifa.arc4_en), 32'd0);
        chk("rst_mid_pt_addr", 32'(ifa.pt_addr), 32'd0);
        chk("rst_mid_key", 32'(key_a), 32'd0);
        p0 = pulses_a;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_pulse", 32'(pulses_a - p0), 32'd0);
        chk("rst_idle", 32'(rdy_a), 32'd1);
        pulse_en(1'b0);
        wait_rdy(1'b0, 500, "restart_timeout");
        chk("restart_key", 32'(key_a), 32'd2);
        chk("restart_kv", 32'(kv_a), 32'd1);
        chk("restart_pulses", 32'(pulses_a - p0), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
